uart_rx: RTL and testbench

8N1 UART receiver that pairs with the existing `uart` transmitter (same `CLK_PER_BAUD` convention, same baud-rate clock domain). It synchronises the asynchronous `rx` line, finds and validates the start bit, and samples each bit at its midpoint. It presents each completed byte with a one-cycle strobe and flags framing errors. It sits between the board RX pin and whatever consumes bytes, such as a FIFO or command parser.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle valid / frame_err strobes.
// A stop bit sampled low parks the receiver in BREAK until the line returns high.
module uart_rx #(
    parameter int unsigned CLK_PER_BAUD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF = CLK_PER_BAUD / 2;
    localparam int unsigned CW   = $clog2(CLK_PER_BAUD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic            r_sync1;
    logic            r_rx_s;
    logic [CW-1:0]   r_baud;
    logic [CW-1:0]   w_baud_n;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_n;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_n;
    logic [7:0]      r_rx_byte;
    logic [7:0]      w_rx_byte_n;
    logic            r_valid;
    logic            w_valid_n;
    logic            r_frame_err;
    logic            w_frame_err_n;
    logic            r_busy;
    logic            w_busy_n;

    // Synchroniser resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_rx_byte   <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_baud      <= w_baud_n;
            r_bit       <= w_bit_n;
            r_shift     <= w_shift_n;
            r_rx_byte   <= w_rx_byte_n;
            r_valid     <= w_valid_n;
            r_frame_err <= w_frame_err_n;
            r_busy      <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_baud_n      = r_baud + CW'(1);
        w_bit_n       = r_bit;
        w_shift_n     = r_shift;
        w_rx_byte_n   = r_rx_byte;
        w_valid_n     = 1'b0;
        w_frame_err_n = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_n = '0;
                if (!r_rx_s) begin
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (r_baud == CW'(HALF - 1)) begin
                    w_baud_n = '0;
                    w_bit_n  = '0;
                    // A line that is high again at mid-start was a glitch.
                    w_state_n = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud == CW'(CLK_PER_BAUD - 1)) begin
                    w_baud_n  = '0;
                    w_shift_n = {r_rx_s, r_shift[7:1]};
                    w_bit_n   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_baud == CW'(CLK_PER_BAUD - 1)) begin
                    w_baud_n = '0;
                    if (r_rx_s) begin
                        w_rx_byte_n = r_shift;
                        w_valid_n   = 1'b1;
                        w_state_n   = S_IDLE;
                    end else begin
                        w_frame_err_n = 1'b1;
                        w_state_n     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_baud_n = '0;
                if (r_rx_s) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_baud_n  = '0;
                w_state_n = S_IDLE;
            end
        endcase

        w_busy_n = (w_state_n != S_IDLE);
    end

    assign rx_byte   = r_rx_byte;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a timing/queue model of the receiver's
// externally visible behaviour (strobe cycle = start edge + fixed latency).
module tb_uart_rx;

    localparam int unsigned CPB  = 4;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int cyc      = 0;
    int total    = 0;
    int passed   = 0;
    int both     = 0;
    int busy_cnt = 0;

    int         exp_t[$];
    logic [7:0] exp_b[$];
    int         exp_e[$];
    int         got_t[$];
    logic [7:0] got_b[$];
    int         got_e[$];

    uart_rx #(.CLK_PER_BAUD(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            got_t.push_back(cyc);
            got_b.push_back(rx_byte);
        end
        if (frame_err) got_e.push_back(cyc);
        if (valid && frame_err) both <= both + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural transmitter; call just after a posedge. Records the expected outcome.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_t.push_back(cyc + int'(LAT));
            exp_b.push_back(b);
        end else begin
            exp_e.push_back(cyc + int'(LAT));
        end
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop_bit;
        wait_cycles(CPB);
    endtask

    task automatic check_frames(input string tag);
        int n;
        chk({tag, "_nvalid"}, 32'(got_t.size()), 32'(exp_t.size()));
        n = (got_t.size() < exp_t.size()) ? got_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_t%0d", tag, i), 32'(got_t[i]), 32'(exp_t[i]));
            chk($sformatf("%s_b%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
        end
        chk({tag, "_nerr"}, 32'(got_e.size()), 32'(exp_e.size()));
        n = (got_e.size() < exp_e.size()) ? got_e.size() : exp_e.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_et%0d", tag, i), 32'(got_e[i]), 32'(exp_e[i]));
        end
        exp_t.delete(); exp_b.delete(); exp_e.delete();
        got_t.delete(); got_b.delete(); got_e.delete();
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] pat;

        // Reset state
        rst = 1'b0;
        rx  = 1'b1;
        wait_cycles(3);
        chk("rst_byte", 32'(rx_byte), 32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        wait_cycles(4);

        // Single ideal frame
        send_frame(8'h55, 1'b1);
        wait_cycles(4);
        check_frames("single");
        chk("single_hold", 32'(rx_byte), 32'h55);

        // Back-to-back frames, no idle gap
        send_frame(8'hA5, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(4);
        chk("b2b_gap", (got_t.size() == 3) ? 32'(got_t[2] - got_t[1]) : 32'hFFFF_FFFF, 32'(10 * CPB));
        check_frames("b2b");

        // One-cycle glitch: busy for HALF cycles, no strobes
        busy_cnt = 0;
        rx = 1'b0;
        wait_cycles(1);
        rx = 1'b1;
        wait_cycles(10);
        chk("glitch_busy", 32'(busy_cnt), 32'(HALF));
        chk("glitch_byte", 32'(rx_byte), 32'hFF);
        check_frames("glitch");
        send_frame(8'h3C, 1'b1);
        wait_cycles(4);
        check_frames("after_glitch");

        // Bad stop bit, line held low, then released
        send_frame(8'h81, 1'b0);
        wait_cycles(30);
        chk("brk_busy", 32'(busy), 32'h1);
        chk("brk_byte", 32'(rx_byte), 32'h3C);
        rx = 1'b1;
        wait_cycles(5);
        chk("brk_exit", 32'(busy), 32'h0);
        check_frames("break");
        send_frame(8'h42, 1'b1);
        wait_cycles(4);
        check_frames("after_break");

        // Reset during data bit 3 of 0xF0
        pat = 8'hF0;
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = pat[i];
            wait_cycles(CPB);
        end
        rx = pat[3];
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(2);
        chk("mid_rst_byte", 32'(rx_byte), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        rx = 1'b1;
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(5);
        send_frame(8'h0F, 1'b1);
        wait_cycles(4);
        check_frames("after_rst");

        // Loopback of a transmitter repeating "0"
        for (int i = 0; i < 3; i++) send_frame(8'h30, 1'b1);
        wait_cycles(4);
        check_frames("loop");

        // Randomized bytes and idle gaps
        last = 8'h30;
        for (int i = 0; i < 16; i++) begin
            last = 8'($urandom);
            send_frame(last, 1'b1);
            rx = 1'b1;
            wait_cycles(int'($urandom_range(0, 3)));
        end
        wait_cycles(4);
        check_frames("rand");
        chk("rand_hold", 32'(rx_byte), 32'(last));
        chk("exclusive", 32'(both), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
